// File: rtl/serial_adder_nbit.sv
// Serial adder/subtractor: processes DIGIT bits per clock, LS slice first,
// and presents the WIDTH-bit sum, carry and two's-complement overflow flags
// together with a one-cycle done pulse.
module serial_adder_nbit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT:0]     slice_c;
    logic               msb_cin_c;
    logic [WIDTH-1:0]   res_next_c;
    logic               last_c;

    // One DIGIT-wide slice of the ripple: add low slice of the shifting operands
    always_comb begin
        slice_c    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
        // carry into the slice MSB recovered from its sum bit
        msb_cin_c  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_c[DIGIT-1];
        res_next_c = WIDTH'({slice_c[DIGIT-1:0], res_q} >> DIGIT);
        last_c     = (cnt_q == CNT_W'(N - 1));
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        res_d       = res_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_c[DIGIT];
                res_d   = res_next_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_d     = DONE;
                    sum_d       = res_next_c;
                    carry_out_d = slice_c[DIGIT];
                    overflow_d  = slice_c[DIGIT] ^ msb_cin_c;
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : carry_in;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            res_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit: one DIGIT=1 and one DIGIT=4 instance.
module tb_serial_adder_nbit;

    logic       clk;
    logic       reset;
    logic       start1, start4;
    logic [7:0] a, b;
    logic       cin, sub;

    logic       busy1, done1, co1, ov1;
    logic [7:0] sum1;
    logic       busy4, done4, co4, ov4;
    logic [7:0] sum4;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start1), .A(a), .B(b),
        .carry_in(cin), .sub(sub), .busy(busy1), .done(done1),
        .sum(sum1), .carry_out(co1), .overflow(ov1)
    );

    serial_adder_nbit #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start4), .A(a), .B(b),
        .carry_in(cin), .sub(sub), .busy(busy4), .done(done4),
        .sum(sum4), .carry_out(co4), .overflow(ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dig;
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic       vsub;
        logic [7:0] esum;
        logic       eco;
        logic       eov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic get_out(input int dig, output logic bz, output logic dn,
                           output logic [7:0] s, output logic c, output logic v);
        if (dig == 1) begin
            bz = busy1; dn = done1; s = sum1; c = co1; v = ov1;
        end else begin
            bz = busy4; dn = done4; s = sum4; c = co4; v = ov4;
        end
    endtask

    task automatic set_start(input int dig, input logic val);
        if (dig == 1) start1 = val;
        else          start4 = val;
    endtask

    // Launch one operation, measure busy cycles and done latency, check done is one cycle
    task automatic run_op(input string name, input int dig, input logic [7:0] va,
                          input logic [7:0] vb, input logic vcin, input logic vsub,
                          input logic [7:0] esum, input logic eco, input logic eov);
        logic bz, dn, c, v;
        logic [7:0] s;
        int busy_cnt;
        int lat;
        int nexp;
        nexp = 8 / dig;
        busy_cnt = 0;
        lat = -1;
        @(negedge clk);
        a = va; b = vb; cin = vcin; sub = vsub;
        set_start(dig, 1'b1);
        @(posedge clk); #1;
        set_start(dig, 1'b0);
        for (int e = 0; e < 20; e++) begin
            get_out(dig, bz, dn, s, c, v);
            if (bz) busy_cnt++;
            if (dn) begin
                lat = e;
                break;
            end
            @(posedge clk); #1;
        end
        chk({name, " latency"}, 64'(lat), 64'(nexp));
        chk({name, " busy cycles"}, 64'(busy_cnt), 64'(nexp));
        chk({name, " sum"}, 64'(s), 64'(esum));
        chk({name, " carry_out"}, 64'(c), 64'(eco));
        chk({name, " overflow"}, 64'(v), 64'(eov));
        @(posedge clk); #1;
        get_out(dig, bz, dn, s, c, v);
        chk({name, " done one cycle"}, 64'(dn), 64'(0));
        chk({name, " sum held"}, 64'(s), 64'(esum));
    endtask

    vec_t vecs[10];

    initial begin
        logic bz, dn, c, v;
        logic [7:0] s;
        logic seen;

        vecs[0] = '{1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{4, 8'h3C, 8'hC4, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{4, 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{4, 8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1};
        vecs[7] = '{1, 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[8] = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[9] = '{4, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("reset busy1", 64'(busy1), 64'(0));
        chk("reset done1", 64'(done1), 64'(0));
        chk("reset sum1", 64'(sum1), 64'(0));
        chk("reset flags1", 64'({co1, ov1}), 64'(0));
        chk("reset busy4", 64'(busy4), 64'(0));
        chk("reset sum4", 64'(sum4), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].dig, vecs[i].va, vecs[i].vb,
                   vecs[i].vcin, vecs[i].vsub, vecs[i].esum, vecs[i].eco, vecs[i].eov);
        end

        // Inputs changed and start re-pulsed during RUN must be ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        seen = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e == 2) begin a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start1 = 1'b1; end
            if (e == 5) start1 = 1'b0;
            if (e < 8 && done1) seen = 1'b1;
        end
        chk("ignore early done", 64'(seen), 64'(0));
        chk("ignore done", 64'(done1), 64'(1));
        chk("ignore sum", 64'(sum1), 64'(8'h46));
        chk("ignore flags", 64'({co1, ov1}), 64'(0));
        @(posedge clk); #1;
        chk("ignore done drop", 64'(done1), 64'(0));

        // Asynchronous reset between edges aborts a running operation
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy1), 64'(0));
        chk("abort done", 64'(done1), 64'(0));
        chk("abort sum", 64'(sum1), 64'(0));
        chk("abort flags", 64'({co1, ov1}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (done1 || busy1) seen = 1'b1;
        end
        chk("abort stays idle", 64'(seen), 64'(0));
        run_op("after abort", 1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Start held across DONE: back-to-back operations on DIGIT=4
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        chk("b2b edge0 done", 64'(done4), 64'(0));
        @(posedge clk); #1;
        chk("b2b edge1 done", 64'(done4), 64'(0));
        @(posedge clk); #1;
        get_out(4, bz, dn, s, c, v);
        chk("b2b op1 done", 64'(dn), 64'(1));
        chk("b2b op1 sum", 64'(s), 64'(8'h33));
        chk("b2b op1 flags", 64'({c, v}), 64'(0));
        a = 8'hF0; b = 8'h0F; cin = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("b2b restart done", 64'(done4), 64'(0));
        chk("b2b restart busy", 64'(busy4), 64'(1));
        chk("b2b held sum", 64'(sum4), 64'(8'h33));
        @(posedge clk); #1;
        chk("b2b op2 mid done", 64'(done4), 64'(0));
        @(posedge clk); #1;
        get_out(4, bz, dn, s, c, v);
        chk("b2b op2 done", 64'(dn), 64'(1));
        chk("b2b op2 sum", 64'(s), 64'(8'h00));
        chk("b2b op2 carry", 64'(c), 64'(1));
        chk("b2b op2 ovf", 64'(v), 64'(0));
        @(posedge clk); #1;
        chk("b2b op2 done drop", 64'(done4), 64'(0));
        chk("b2b idle busy", 64'(busy4), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
